// File: rtl/storebuffer_mc.sv
// storebuffer_mc: age-ordered store buffer between the LSU store pipe and the
// D-cache write port. Speculative stores are allocated at head, committed in
// order at cptr (up to COMMIT_WIDTH per cycle) and drained one per cycle from
// tail. Loads see the youngest matching bytes of any valid entry.
module storebuffer_mc #(
  parameter int unsigned SB_SIZE      = 8,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STRB_W       = DATA_W / 8,
  parameter int unsigned CNT_W        = $clog2(SB_SIZE) + 1,
  parameter int unsigned CN_W         = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [STRB_W-1:0] in_strb_i,
  input  logic [CN_W-1:0]   commit_num_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [STRB_W-1:0] out_strb_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [STRB_W-1:0] fwd_mask_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [CNT_W-1:0]  commit_cnt_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(SB_SIZE);
  localparam int unsigned OFF_W = $clog2(STRB_W);

  // Entry storage
  logic [SB_SIZE-1:0] valid_q, valid_d;
  logic [SB_SIZE-1:0] commit_q, commit_d;
  logic [ADDR_W-1:0]  addr_q [SB_SIZE];
  logic [DATA_W-1:0]  data_q [SB_SIZE];
  logic [STRB_W-1:0]  strb_q [SB_SIZE];

  // Pointers and occupancy
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] cptr_q, cptr_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] uncommitted;
  logic [CNT_W-1:0] num_ext;
  logic [CNT_W-1:0] eff;

  // Handshake and drain outputs come straight from registered state
  assign in_ready_o   = (cnt_q < CNT_W'(SB_SIZE));
  assign out_valid_o  = valid_q[tail_q] & commit_q[tail_q];
  assign out_addr_o   = addr_q[tail_q];
  assign out_data_o   = data_q[tail_q];
  assign out_strb_o   = strb_q[tail_q];
  assign cnt_o        = cnt_q;
  assign commit_cnt_o = ccnt_q;
  assign empty_o      = (cnt_q == '0);

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;

  // Commit count clamped to the uncommitted population, suppressed on flush
  always_comb begin
    uncommitted = cnt_q - ccnt_q;
    num_ext     = CNT_W'(commit_num_i);
    eff         = '0;
    if (!flush_i) begin
      eff = (num_ext < uncommitted) ? num_ext : uncommitted;
    end
  end

  // Next-state for entry flags, pointers and counters
  always_comb begin
    valid_d  = valid_q;
    commit_d = commit_q;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      if (CNT_W'(k) < eff) begin
        commit_d[cptr_q + PTR_W'(k)] = 1'b1;
      end
    end
    if (pop) begin
      valid_d[tail_q]  = 1'b0;
      commit_d[tail_q] = 1'b0;
    end
    if (push) begin
      valid_d[head_q]  = 1'b1;
      commit_d[head_q] = 1'b0;
    end
    // eff is zero and push is blocked on flush, so commit_d here holds exactly
    // the committed survivors (minus any entry popped this cycle)
    if (flush_i) begin
      valid_d = valid_d & commit_d;
    end

    tail_d = tail_q + PTR_W'(pop);
    cptr_d = cptr_q + PTR_W'(eff);
    ccnt_d = ccnt_q + eff - CNT_W'(pop);
    if (flush_i) begin
      head_d = cptr_q;
      cnt_d  = ccnt_d;
    end else begin
      head_d = head_q + PTR_W'(push);
      cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Youngest-wins byte forwarding, walking entries from oldest (tail) upward
  always_comb begin
    logic [PTR_W-1:0] slot;
    fwd_data_o = '0;
    fwd_mask_o = '0;
    slot       = '0;
    for (int unsigned j = 0; j < SB_SIZE; j++) begin
      slot = tail_q + PTR_W'(j);
      if (valid_q[slot] &&
          (addr_q[slot][ADDR_W-1:OFF_W] == ld_addr_i[ADDR_W-1:OFF_W])) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (strb_q[slot][b]) begin
            fwd_data_o[8*b +: 8] = data_q[slot][8*b +: 8];
            fwd_mask_o[b]        = 1'b1;
          end
        end
      end
    end
  end

  generate
    if (OFF_W > 0) begin : g_unused_off
      logic unused_ld_off;
      assign unused_ld_off = ^ld_addr_i[OFF_W-1:0];
    end
  endgenerate

  // State registers and payload write on allocation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      commit_q <= '0;
      head_q   <= '0;
      cptr_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      ccnt_q   <= '0;
      addr_q   <= '{default: '0};
      data_q   <= '{default: '0};
      strb_q   <= '{default: '0};
    end else begin
      valid_q  <= valid_d;
      commit_q <= commit_d;
      head_q   <= head_d;
      cptr_q   <= cptr_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      ccnt_q   <= ccnt_d;
      if (push) begin
        addr_q[head_q] <= in_addr_i;
        data_q[head_q] <= in_data_i;
        strb_q[head_q] <= in_strb_i;
      end
    end
  end

endmodule

// File: tb/tb_storebuffer_mc.sv
// Directed bench for storebuffer_mc with hand-computed expectations.
module tb_storebuffer_mc;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_addr_i;
  logic [31:0] in_data_i;
  logic [3:0]  in_strb_i;
  logic [1:0]  commit_num_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_addr_o;
  logic [31:0] out_data_o;
  logic [3:0]  out_strb_o;
  logic [31:0] ld_addr_i;
  logic [31:0] fwd_data_o;
  logic [3:0]  fwd_mask_o;
  logic [3:0]  cnt_o;
  logic [3:0]  commit_cnt_o;
  logic        empty_o;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned failed = 0;

  storebuffer_mc #(
    .SB_SIZE(8),
    .COMMIT_WIDTH(2),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_addr_i(in_addr_i),
    .in_data_i(in_data_i),
    .in_strb_i(in_strb_i),
    .commit_num_i(commit_num_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o),
    .out_data_o(out_data_o),
    .out_strb_o(out_strb_o),
    .ld_addr_i(ld_addr_i),
    .fwd_data_o(fwd_data_o),
    .fwd_mask_o(fwd_mask_o),
    .cnt_o(cnt_o),
    .commit_cnt_o(commit_cnt_o),
    .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i      = 1'b0;
    in_valid_i   = 1'b0;
    in_addr_i    = '0;
    in_data_i    = '0;
    in_strb_i    = '0;
    commit_num_i = '0;
    out_ready_i  = 1'b0;
    ld_addr_i    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    // Reset state
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_ccnt", commit_cnt_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_fwd_mask", fwd_mask_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: fill with 8 stores, no drain
    for (int i = 0; i < 8; i++) begin
      in_valid_i = 1'b1;
      in_addr_i  = 32'h100 + 32'(4 * i);
      in_data_i  = 32'(i);
      in_strb_i  = 4'hF;
      #1;
      chk("t1_ready_before_push", in_ready_o, 1);
      tick();
    end
    chk("t1_full_ready", in_ready_o, 0);
    chk("t1_full_cnt", cnt_o, 8);
    chk("t1_out_valid", out_valid_o, 0);
    chk("t1_not_empty", empty_o, 0);
    // push attempt when full is refused
    in_addr_i = 32'h900;
    tick();
    chk("t1_full_push_refused", cnt_o, 8);
    in_valid_i = 1'b0;

    // 2: commit two, drain them
    commit_num_i = 2'd2;
    out_ready_i  = 1'b1;
    tick();
    commit_num_i = 2'd0;
    chk("t2_ccnt", commit_cnt_o, 2);
    chk("t2_cnt", cnt_o, 8);
    chk("t2_out_valid", out_valid_o, 1);
    chk("t2_out_addr0", out_addr_o, 32'h100);
    chk("t2_out_data0", out_data_o, 0);
    tick();
    chk("t2_out_addr1", out_addr_o, 32'h104);
    chk("t2_out_data1", out_data_o, 1);
    chk("t2_cnt_after1", cnt_o, 7);
    tick();
    chk("t2_cnt_end", cnt_o, 6);
    chk("t2_ccnt_end", commit_cnt_o, 0);
    chk("t2_out_valid_end", out_valid_o, 0);
    chk("t2_ready_again", in_ready_o, 1);

    // 3: flush keeps committed entries only
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      in_addr_i  = 32'h300 + 32'(4 * i);
      in_data_i  = 32'hA0 + 32'(i);
      in_strb_i  = 4'hF;
      tick();
    end
    in_valid_i   = 1'b0;
    commit_num_i = 2'd1;
    tick();
    commit_num_i = 2'd0;
    ld_addr_i    = 32'h30C;
    #1;
    chk("t3_fwd_uncommitted_mask", fwd_mask_o, 4'hF);
    chk("t3_fwd_uncommitted_data", fwd_data_o, 32'hA3);
    flush_i      = 1'b1;
    in_valid_i   = 1'b1;
    in_addr_i    = 32'h3F0;
    commit_num_i = 2'd2;
    tick();
    flush_i      = 1'b0;
    in_valid_i   = 1'b0;
    commit_num_i = 2'd0;
    chk("t3_flush_cnt", cnt_o, 1);
    chk("t3_flush_ccnt", commit_cnt_o, 1);
    chk("t3_flush_fwd_gone", fwd_mask_o, 0);
    chk("t3_survivor_valid", out_valid_o, 1);
    chk("t3_survivor_addr", out_addr_o, 32'h300);
    // push lands right after the survivor while the survivor drains
    in_valid_i  = 1'b1;
    in_addr_i   = 32'h340;
    in_data_i   = 32'hB0;
    out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("t3_post_push_cnt", cnt_o, 1);
    chk("t3_post_push_ccnt", commit_cnt_o, 0);
    chk("t3_post_push_valid", out_valid_o, 0);
    commit_num_i = 2'd1;
    tick();
    commit_num_i = 2'd0;
    chk("t3_new_valid", out_valid_o, 1);
    chk("t3_new_addr", out_addr_o, 32'h340);
    chk("t3_new_data", out_data_o, 32'hB0);
    tick();
    out_ready_i = 1'b0;
    chk("t3_drained_cnt", cnt_o, 0);
    chk("t3_drained_empty", empty_o, 1);
    chk("t3_drained_valid", out_valid_o, 0);

    // 4: youngest-wins forwarding
    in_valid_i = 1'b1;
    in_addr_i  = 32'h200;
    in_data_i  = 32'h11223344;
    in_strb_i  = 4'hF;
    tick();
    in_addr_i  = 32'h202;
    in_data_i  = 32'hAABB0000;
    in_strb_i  = 4'hC;
    tick();
    in_valid_i = 1'b0;
    ld_addr_i  = 32'h200;
    #1;
    chk("t4_fwd_mask", fwd_mask_o, 4'hF);
    chk("t4_fwd_data", fwd_data_o, 32'hAABB3344);
    ld_addr_i = 32'h203;
    #1;
    chk("t4_fwd_data_unaligned", fwd_data_o, 32'hAABB3344);
    ld_addr_i = 32'h204;
    #1;
    chk("t4_fwd_miss", fwd_mask_o, 0);

    // 5: commit clamped to uncommitted count; same-cycle push not committed
    commit_num_i = 2'd1;
    tick();
    chk("t5_ccnt1", commit_cnt_o, 1);
    commit_num_i = 2'd2;
    in_valid_i   = 1'b1;
    in_addr_i    = 32'h208;
    in_data_i    = 32'h55;
    in_strb_i    = 4'h1;
    tick();
    in_valid_i = 1'b0;
    chk("t5_ccnt_clamped", commit_cnt_o, 2);
    chk("t5_cnt", cnt_o, 3);
    tick();
    chk("t5_ccnt_all", commit_cnt_o, 3);
    tick();
    commit_num_i = 2'd0;
    chk("t5_ccnt_saturated", commit_cnt_o, 3);
    chk("t5_cnt_same", cnt_o, 3);

    // 6: steady push/commit/pop with wrap, then async reset mid-stream
    do_reset();
    in_valid_i = 1'b1;
    in_strb_i  = 4'hF;
    in_addr_i  = 32'h400;
    in_data_i  = 32'hD000;
    tick();
    in_addr_i    = 32'h404;
    in_data_i    = 32'hD001;
    commit_num_i = 2'd1;
    tick();
    out_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_addr_i = 32'h400 + 32'(4 * (k + 2));
      in_data_i = 32'hD000 + 32'(k + 2);
      #1;
      chk("t6_out_valid", out_valid_o, 1);
      chk("t6_out_addr", out_addr_o, 32'h400 + 32'(4 * k));
      chk("t6_out_data", out_data_o, 32'hD000 + 32'(k));
      chk("t6_cnt", cnt_o, 2);
      tick();
    end
    in_valid_i   = 1'b0;
    commit_num_i = 2'd0;
    out_ready_i  = 1'b0;
    ld_addr_i    = 32'h400 + 32'(4 * 21);
    #1;
    chk("t6_pre_rst_fwd", fwd_mask_o, 4'hF);
    chk("t6_pre_rst_ccnt", commit_cnt_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", in_ready_o, 1);
    chk("t6_rst_out_valid", out_valid_o, 0);
    chk("t6_rst_cnt", cnt_o, 0);
    chk("t6_rst_ccnt", commit_cnt_o, 0);
    chk("t6_rst_empty", empty_o, 1);
    chk("t6_rst_fwd_mask", fwd_mask_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_after_rst_cnt", cnt_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/storebuffer_mc.md
Name: storebuffer_mc

Overview:
- Parametrised store buffer between the LSU store pipe and the D-cache write port.
- Holds speculative stores in age order and retires up to COMMIT_WIDTH of them per cycle on ROB commit.
- Drains committed stores one per cycle to the cache and forwards youngest matching store bytes to loads.
- On flush, discards uncommitted entries while keeping committed ones.

Parameters:
SB_SIZE, 8, number of entries; power of two, >=2
COMMIT_WIDTH, 2, maximum stores committed per cycle
ADDR_W, 32, byte address width
DATA_W, 32, store data width; STRB_W = DATA_W/8
CNT_W, $clog2(SB_SIZE)+1, occupancy counter width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; drops all uncommitted entries
in_valid_i  in  1  store allocation request
in_ready_o  out  1  buffer can accept a store
in_addr_i  in  ADDR_W  store byte address
in_data_i  in  DATA_W  store data, byte-lane aligned
in_strb_i  in  STRB_W  byte write enables
commit_num_i  in  $clog2(COMMIT_WIDTH+1)  stores to commit this cycle (0..COMMIT_WIDTH)
out_valid_o  out  1  oldest entry is committed and ready to write
out_ready_i  in  1  cache accepts write
out_addr_o  out  ADDR_W  drain address
out_data_o  out  DATA_W  drain data
out_strb_o  out  STRB_W  drain strobes
ld_addr_i  in  ADDR_W  load lookup address
fwd_data_o  out  DATA_W  forwarded bytes (don't-care where mask=0)
fwd_mask_o  out  STRB_W  bytes supplied by the buffer
cnt_o  out  CNT_W  valid entries
commit_cnt_o  out  CNT_W  committed, not yet drained entries
empty_o  out  1  cnt_o==0 (fence/uncached gate)

Behaviour:
- Reset (async, rst_n=0): all pointers, counters and entry valid/commit bits are 0. in_ready_o=1, out_valid_o=0, cnt_o=0, commit_cnt_o=0, empty_o=1, fwd_mask_o=0.
- Storage is a circular array. Pointers are $clog2(SB_SIZE) bits wide and wrap naturally:
  - head: next allocation slot.
  - cptr: oldest uncommitted entry.
  - tail: oldest entry.
- Push = in_valid_i & in_ready_o & ~flush_i.
  - Writes addr/data/strb into slot head, with valid=1, commit=0.
  - head advances by 1.
  - in_ready_o = (cnt_o < SB_SIZE), registered-state only; there is no same-cycle pop bypass.
- Commit: eff = min(commit_num_i, cnt_o - commit_cnt_o), forced to 0 when flush_i=1.
  - Entries cptr..cptr+eff-1 get commit=1; cptr advances by eff.
  - A push in the same cycle is never committed that cycle.
- Pop = out_valid_o & out_ready_i.
  - out_valid_o = valid & commit of slot tail; out_* show slot tail combinationally.
  - Pop clears valid/commit of slot tail; tail advances by 1.
  - Pop is honoured even in a flush cycle.
- Counters:
  - cnt_next = cnt_o + push - pop.
  - commit_cnt_next = commit_cnt_o + eff - pop.
  - Invariant: commit_cnt_o <= cnt_o <= SB_SIZE.
- Flush cycle:
  - Every entry with commit=0 is invalidated.
  - head <= cptr; cnt <= commit_cnt_next; commit_cnt <= commit_cnt_next.
  - tail moves normally with pop.
  - Committed entries survive and keep draining.
- Forwarding (combinational, zero latency):
  - Candidates are valid entries (committed or not) whose addr[ADDR_W-1:$clog2(STRB_W)] equals that of ld_addr_i.
  - Per byte lane, the youngest candidate with strb set supplies the byte; age is measured from tail.
  - fwd_mask_o is the OR of the candidate strobes. Entries being pushed this cycle are not visible.
- Full: cnt_o==SB_SIZE. Push plus pop in the same cycle when full is impossible, because in_ready_o=0.
- Empty: out_valid_o=0 and fwd_mask_o=0. Commit with cnt_o==0 is clamped to 0.

Test Plan:
1. Push 8 stores (addr 0x100+4i, data i, strb 0xF) with out_ready_i=0 -> in_ready_o=0 after 8th, cnt_o=8, out_valid_o=0.
2. From state 1, commit_num_i=2 for 1 cycle, out_ready_i=1 -> commit_cnt_o=2. Next cycle out_addr_o=0x100, then 0x104 drained on consecutive cycles; cnt_o ends 6, commit_cnt_o 0.
3. Push 4 stores, commit 1, assert flush_i with out_ready_i=0 -> cnt_o=1, commit_cnt_o=1, head==cptr. The next push lands in slot 1, and the committed store still drains.
4. Push st 0x200 data 0x11223344 strb 0xF, then st 0x202 data 0xAABB0000 strb 0xC. Load 0x200 -> fwd_mask_o=0xF, fwd_data_o=0xAABB3344. Load 0x204 -> fwd_mask_o=0.
5. commit_num_i=2 with only 1 uncommitted entry -> commit_cnt_o grows by 1 only, cptr==head.
6. Wrap: 20 push/commit/drain cycles with simultaneous push, commit and pop each cycle -> cnt_o constant, data drained in push order, no drop or duplication; assert rst_n low mid-stream -> all outputs at reset values immediately.
